// File: rtl/nd_2to1_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : nd_2to1_arb_if
//  Description : One 4-phase req/ack message channel {src,dst,dat,red}.
//                The sender uses the master modport; the receiver uses slave.
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

interface nd_2to1_arb_if #(
   parameter int ASZ = `NS_ADDRESS_SIZE,
   parameter int DSZ = `NS_DATA_SIZE,
   parameter int RSZ = `NS_REDUN_SIZE
);
   logic [ASZ-1:0] src;
   logic [ASZ-1:0] dst;
   logic [DSZ-1:0] dat;
   logic [RSZ-1:0] red;
   logic           req;
   logic           ack;

   modport master (output src, output dst, output dat, output red, output req, input ack);
   modport slave  (input src, input dst, input dat, input red, input req, output ack);
endinterface

`default_nettype wire

// File: rtl/nd_2to1_arb.sv
`default_nettype none
// ============================================================================
//  Module      : nd_2to1_arb
//  Description : Two-input merge node. Round-robin arbitration of rcv0/rcv1
//                into a shared message FIFO, drained onto snd0 (4-phase).
//                Optional macro NS_ARB_FIXED_PRIO_EN: rcv0 wins every tie.
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef NS_MESSAGE_FIFO_SIZE
`define NS_MESSAGE_FIFO_SIZE 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_2to1_arb #(
   parameter int FSZ = `NS_MESSAGE_FIFO_SIZE,
   parameter int ASZ = `NS_ADDRESS_SIZE,
   parameter int DSZ = `NS_DATA_SIZE,
   parameter int RSZ = `NS_REDUN_SIZE
) (
   input  logic           i_clk,
   input  logic           reset,
   output logic           ready,
   nd_2to1_arb_if.slave   rcv0,
   nd_2to1_arb_if.slave   rcv1,
   nd_2to1_arb_if.master  snd0
);

   localparam int c_ptr_w = $clog2(FSZ);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam int c_msg_w = 2*ASZ + DSZ + RSZ;

   localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(FSZ);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_LOW = 2'd2
   } state_t;

   state_t               r_state;
   logic                 r_ready;
   logic [c_ptr_w-1:0]   r_head;
   logic [c_ptr_w-1:0]   r_tail;
   logic [c_cnt_w-1:0]   r_count;
   logic                 r_ack0;
   logic                 r_ack1;
   logic [c_msg_w-1:0]   r_mem [FSZ];

   logic [ASZ-1:0]       r_snd_src;
   logic [ASZ-1:0]       r_snd_dst;
   logic [DSZ-1:0]       r_snd_dat;
   logic [RSZ-1:0]       r_snd_red;
   logic                 r_snd_req;

`ifndef NS_ARB_FIXED_PRIO_EN
   logic                 r_prio;
`endif

   logic                 w_not_full;
   logic                 w_elig0;
   logic                 w_elig1;
   logic                 w_grant0;
   logic                 w_grant1;
   logic                 w_push;
   logic                 w_pop;
   logic [c_msg_w-1:0]   w_wr_msg;
   logic [c_msg_w-1:0]   w_head_msg;
   logic [ASZ-1:0]       w_h_src;
   logic [ASZ-1:0]       w_h_dst;
   logic [DSZ-1:0]       w_h_dat;
   logic [RSZ-1:0]       w_h_red;

   // An input with its ack still high is mid-handshake and cannot be granted again.
   assign w_not_full = (r_count != c_full);
   assign w_elig0    = r_ready & rcv0.req & ~r_ack0 & w_not_full;
   assign w_elig1    = r_ready & rcv1.req & ~r_ack1 & w_not_full;

`ifdef NS_ARB_FIXED_PRIO_EN
   assign w_grant0 = w_elig0;
   assign w_grant1 = w_elig1 & ~w_elig0;
`else
   assign w_grant0 = w_elig0 & (~w_elig1 | ~r_prio);
   assign w_grant1 = w_elig1 & ~w_grant0;
`endif

   assign w_push   = w_grant0 | w_grant1;
   assign w_pop    = r_ready & (r_state == ST_IDLE) & (r_count != '0);
   assign w_wr_msg = w_grant0 ? {rcv0.src, rcv0.dst, rcv0.dat, rcv0.red}
                              : {rcv1.src, rcv1.dst, rcv1.dat, rcv1.red};

   assign w_head_msg = r_mem[r_head];
   assign {w_h_src, w_h_dst, w_h_dat, w_h_red} = w_head_msg;

   // Storage carries no reset; validity is tracked entirely by head/tail/count.
   always_ff @(posedge i_clk) begin
      if (!reset && w_push) begin
         r_mem[r_tail] <= w_wr_msg;
      end
   end

   always_ff @(posedge i_clk) begin
      if (reset || !r_ready) begin
         // The first edge out of reset re-clears everything and raises ready.
         r_ready   <= ~reset;
         r_state   <= ST_IDLE;
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_ack0    <= 1'b0;
         r_ack1    <= 1'b0;
         r_snd_src <= '0;
         r_snd_dst <= '0;
         r_snd_dat <= '0;
         r_snd_red <= '0;
         r_snd_req <= 1'b0;
`ifndef NS_ARB_FIXED_PRIO_EN
         r_prio    <= 1'b0;
`endif
      end else begin
         if (w_grant0) begin
            r_ack0 <= 1'b1;
         end else if (r_ack0 && !rcv0.req) begin
            r_ack0 <= 1'b0;
         end

         if (w_grant1) begin
            r_ack1 <= 1'b1;
         end else if (r_ack1 && !rcv1.req) begin
            r_ack1 <= 1'b0;
         end

         if (w_push) begin
            r_tail <= r_tail + c_ptr_one;
`ifndef NS_ARB_FIXED_PRIO_EN
            r_prio <= w_grant0;
`endif
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase

         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_snd_src <= w_h_src;
                  r_snd_dst <= w_h_dst;
                  r_snd_dat <= w_h_dat;
                  r_snd_red <= w_h_red;
                  r_snd_req <= 1'b1;
                  r_head    <= r_head + c_ptr_one;
                  r_state   <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (snd0.ack) begin
                  r_snd_req <= 1'b0;
                  r_state   <= ST_WAIT_LOW;
               end
            end
            ST_WAIT_LOW: begin
               if (!snd0.ack) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ready     = r_ready;
   assign rcv0.ack  = r_ack0;
   assign rcv1.ack  = r_ack1;
   assign snd0.src  = r_snd_src;
   assign snd0.dst  = r_snd_dst;
   assign snd0.dat  = r_snd_dat;
   assign snd0.red  = r_snd_red;
   assign snd0.req  = r_snd_req;

endmodule

`default_nettype wire

// File: tb/tb_nd_2to1_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nd_2to1_arb
//  Description : Directed self-checking bench for the nd_2to1_arb merge node.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_nd_2to1_arb;

   localparam int FSZ = 4;
   localparam int ASZ = 8;
   localparam int DSZ = 16;
   localparam int RSZ = 4;

   logic i_clk;
   logic reset;
   logic ready;

   nd_2to1_arb_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) rcv0_if ();
   nd_2to1_arb_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) rcv1_if ();
   nd_2to1_arb_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) snd0_if ();

   nd_2to1_arb #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_dut (
      .i_clk (i_clk),
      .reset (reset),
      .ready (ready),
      .rcv0  (rcv0_if),
      .rcv1  (rcv1_if),
      .snd0  (snd0_if)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic           auto_ack = 1'b0;
   logic [DSZ-1:0] tx0[$];
   logic [DSZ-1:0] tx1[$];
   int             g_ch[$];
   logic [DSZ-1:0] g_dat[$];
   logic [ASZ-1:0] rx_src[$];
   logic [DSZ-1:0] rx_dat[$];

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Output-side receiver: acks one cycle after req and records what it saw.
   initial begin
      forever begin
         @(posedge i_clk);
         #2;
         if (auto_ack) begin
            if (snd0_if.req && !snd0_if.ack) begin
               snd0_if.ack = 1'b1;
               rx_src.push_back(snd0_if.src);
               rx_dat.push_back(snd0_if.dat);
            end else if (!snd0_if.req && snd0_if.ack) begin
               snd0_if.ack = 1'b0;
            end
         end
      end
   end

   // Input-side senders: 4-phase, one message from each tx queue per handshake.
   task automatic sender_step();
      if (rcv0_if.req && rcv0_if.ack) begin
         g_ch.push_back(0);
         g_dat.push_back(rcv0_if.dat);
         rcv0_if.req = 1'b0;
      end else if (!rcv0_if.req && !rcv0_if.ack && tx0.size() > 0) begin
         rcv0_if.dat = tx0.pop_front();
         rcv0_if.req = 1'b1;
      end
      if (rcv1_if.req && rcv1_if.ack) begin
         g_ch.push_back(1);
         g_dat.push_back(rcv1_if.dat);
         rcv1_if.req = 1'b0;
      end else if (!rcv1_if.req && !rcv1_if.ack && tx1.size() > 0) begin
         rcv1_if.dat = tx1.pop_front();
         rcv1_if.req = 1'b1;
      end
   endtask

   task automatic reset_init();
      auto_ack    = 1'b0;
      snd0_if.ack = 1'b0;
      rcv0_if.req = 1'b0;
      rcv1_if.req = 1'b0;
      tx0.delete();
      tx1.delete();
      g_ch.delete();
      g_dat.delete();
      rx_src.delete();
      rx_dat.delete();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      logic [DSZ-1:0] exp_rr [7];
      logic [DSZ-1:0] exp0[$];
      logic [DSZ-1:0] exp1[$];
      logic [DSZ-1:0] v;
      int             i0;
      int             i1;

      reset       = 1'b1;
      snd0_if.ack = 1'b0;
      rcv0_if.src = 8'd0;  rcv0_if.dst = 8'd5;  rcv0_if.dat = '0; rcv0_if.red = 4'h3; rcv0_if.req = 1'b0;
      rcv1_if.src = 8'd1;  rcv1_if.dst = 8'd9;  rcv1_if.dat = '0; rcv1_if.red = 4'hC; rcv1_if.req = 1'b0;

      // ---------------- reset / init ----------------
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_ready", ready, 1'b0);
         check("rst_sreq", snd0_if.req, 1'b0);
         check("rst_acks", {rcv0_if.ack, rcv1_if.ack}, 2'b00);
      end
      check("rst_sdat", snd0_if.dat, 16'h0);
      reset = 1'b0;
      #1;
      check("init_ready_pre", ready, 1'b0);
      step();
      check("init_ready", ready, 1'b1);
      check("init_acks", {rcv0_if.ack, rcv1_if.ack, snd0_if.req}, 3'b000);

      // ---------------- single pass ----------------
      auto_ack    = 1'b1;
      rcv0_if.dst = 8'd5;
      rcv0_if.dat = 16'h0011;
      rcv0_if.req = 1'b1;
      step();
      check("sp_ack_up", rcv0_if.ack, 1'b1);
      check("sp_sreq_lo", snd0_if.req, 1'b0);
      rcv0_if.req = 1'b0;
      step();
      check("sp_ack_dn", rcv0_if.ack, 1'b0);
      check("sp_sreq_hi", snd0_if.req, 1'b1);
      check("sp_dst", snd0_if.dst, 8'd5);
      check("sp_dat", snd0_if.dat, 16'h0011);
      check("sp_red", snd0_if.red, 4'h3);
      step();
      check("sp_sreq_rel", snd0_if.req, 1'b0);
      repeat (4) step();
      check("sp_rx_cnt", rx_dat.size(), 1);

      // ---------------- round robin, fill, stall ----------------
      reset_init();
      tx0 = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
      tx1 = '{16'h0200, 16'h0201, 16'h0202};
      sender_step();
      for (int i = 0; i < 5; i++) begin
         step();
         sender_step();
      end
      check("rr_ngrant", g_ch.size(), 5);
      for (int i = 0; i < g_ch.size() && i < 5; i++) begin
         check($sformatf("rr_grant%0d", i), g_ch[i], i % 2);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         check("full_ack1", rcv1_if.ack, 1'b0);
         sender_step();
      end
      check("full_ngrant", g_ch.size(), 5);
      check("full_hold_req", snd0_if.req, 1'b1);
      check("full_hold_dat", snd0_if.dat, 16'h0100);

      // one output handshake frees one slot
      snd0_if.ack = 1'b1;
      rx_src.push_back(snd0_if.src);
      rx_dat.push_back(snd0_if.dat);
      step();
      check("rel_sreq_dn", snd0_if.req, 1'b0);
      snd0_if.ack = 1'b0;
      step();
      step();
      check("rel_sreq_up", snd0_if.req, 1'b1);
      check("rel_dat", snd0_if.dat, 16'h0200);
      check("rel_ack1_pre", rcv1_if.ack, 1'b0);
      step();
`ifdef NS_ARB_FIXED_PRIO_EN
      check("rel_fix_ack0", rcv0_if.ack, 1'b1);
      check("rel_fix_ack1", rcv1_if.ack, 1'b0);
      exp_rr = '{16'h0100, 16'h0200, 16'h0101, 16'h0201, 16'h0102, 16'h0103, 16'h0202};
`else
      check("rel_rr_ack1", rcv1_if.ack, 1'b1);
      check("rel_rr_ack0", rcv0_if.ack, 1'b0);
      exp_rr = '{16'h0100, 16'h0200, 16'h0101, 16'h0201, 16'h0102, 16'h0202, 16'h0103};
`endif
      sender_step();
      auto_ack = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         sender_step();
      end
      check("rr_rx_cnt", rx_dat.size(), 7);
      for (int i = 0; i < rx_dat.size() && i < 7; i++) begin
         check($sformatf("rr_rx%0d", i), rx_dat[i], exp_rr[i]);
      end

      // ---------------- random traffic, concurrent push/pop ----------------
      reset_init();
      auto_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         v = DSZ'($urandom_range(0, 65535));
         tx0.push_back(v);
         exp0.push_back(v);
         v = DSZ'($urandom_range(0, 65535));
         tx1.push_back(v);
         exp1.push_back(v);
      end
      sender_step();
      for (int c = 0; c < 600 && rx_dat.size() < 20; c++) begin
         step();
         sender_step();
      end
      repeat (10) step();
      check("rand_rx_cnt", rx_dat.size(), 20);
      i0 = 0;
      i1 = 0;
      for (int i = 0; i < rx_dat.size(); i++) begin
         if (rx_src[i] == 8'd0) begin
            if (i0 < exp0.size()) check($sformatf("rand_c0_%0d", i0), rx_dat[i], exp0[i0]);
            else                  check("rand_c0_extra", i0 + 1, exp0.size());
            i0++;
         end else begin
            if (i1 < exp1.size()) check($sformatf("rand_c1_%0d", i1), rx_dat[i], exp1[i1]);
            else                  check("rand_c1_extra", i1 + 1, exp1.size());
            i1++;
         end
      end
      check("rand_n0", i0, 10);
      check("rand_n1", i1, 10);

      // ---------------- mid-operation reset ----------------
      reset_init();
      tx0 = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03};
      sender_step();
      for (int i = 0; i < 7; i++) begin
         step();
         sender_step();
      end
      check("mid_ngrant", g_ch.size(), 4);
      check("mid_sreq_pre", snd0_if.req, 1'b1);
      reset       = 1'b1;
      rcv0_if.req = 1'b0;
      tx0.delete();
      step();
      check("mid_sreq", snd0_if.req, 1'b0);
      check("mid_ready", ready, 1'b0);
      check("mid_ack0", rcv0_if.ack, 1'b0);
      reset = 1'b0;
      step();
      check("mid_reinit", ready, 1'b1);
      auto_ack = 1'b1;
      repeat (10) step();
      check("mid_no_stale", rx_dat.size(), 0);
      tx0.push_back(16'hABCD);
      sender_step();
      for (int i = 0; i < 10; i++) begin
         step();
         sender_step();
      end
      check("mid_post_cnt", rx_dat.size(), 1);
      if (rx_dat.size() > 0) check("mid_post_dat", rx_dat[0], 16'hABCD);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
